// File: rtl/stream_demux_if.sv
// Handshake bundle between an upstream source, the 1:2 demux and its two downstream sinks.
interface stream_demux_if #(
   parameter int unsigned WIDTH = 8
);
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_last;
   logic             in_ready;
   logic             sel;
   logic [WIDTH-1:0] out0_data;
   logic             out0_valid;
   logic             out0_last;
   logic             out0_ready;
   logic [WIDTH-1:0] out1_data;
   logic             out1_valid;
   logic             out1_last;
   logic             out1_ready;

   modport master (
      output in_data, in_valid, in_last, sel, out0_ready, out1_ready,
      input  in_ready, out0_data, out0_valid, out0_last, out1_data, out1_valid, out1_last
   );

   modport slave (
      input  in_data, in_valid, in_last, sel, out0_ready, out1_ready,
      output in_ready, out0_data, out0_valid, out0_last, out1_data, out1_valid, out1_last
   );
endinterface

// File: rtl/stream_demux.sv
// Packet-aware 1:2 stream demux: route locked on the first beat, one register slice per
// output port, per-port completed-packet counters.
module stream_demux #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNTW  = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   stream_demux_if.slave   bus,
   output logic            busy,
   output logic            route,
   output logic [CNTW-1:0] pkt_cnt0,
   output logic [CNTW-1:0] pkt_cnt1
);
   typedef enum logic [1:0] {IDLE, PKT0, PKT1} state_t;

   state_t           state_q, state_d;
   logic             busy_q, route_q;
   logic             v0_q, l0_q, v1_q, l1_q;
   logic [WIDTH-1:0] d0_q, d1_q;
   logic [CNTW-1:0]  cnt0_q, cnt1_q;

   logic target, free, rdy_c, accept, load0, load1;

   // Target port, acceptance and next state
   always_comb begin
      state_d = state_q;
      target  = 1'b0;
      case (state_q)
         IDLE:    target = bus.sel;
         PKT0:    target = 1'b0;
         PKT1:    target = 1'b1;
         default: target = 1'b0;
      endcase
      free   = target ? (!v1_q || bus.out1_ready) : (!v0_q || bus.out0_ready);
      rdy_c  = rst_n && free;
      accept = bus.in_valid && rdy_c;
      load0  = accept && !target;
      load1  = accept && target;
      case (state_q)
         IDLE: begin
            if (accept && !bus.in_last) state_d = target ? PKT1 : PKT0;
         end
         PKT0, PKT1: begin
            if (accept && bus.in_last) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State register; busy/route decoded from the next state so they are registered
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
         route_q <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= (state_d != IDLE);
         route_q <= (state_d == PKT1);
      end
   end

   // Output slices: load wins over drain so a simultaneous drain+load has no bubble
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v0_q   <= 1'b0;
         l0_q   <= 1'b0;
         d0_q   <= '0;
         v1_q   <= 1'b0;
         l1_q   <= 1'b0;
         d1_q   <= '0;
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else begin
         if (load0) begin
            v0_q <= 1'b1;
            d0_q <= bus.in_data;
            l0_q <= bus.in_last;
         end else if (bus.out0_ready) begin
            v0_q <= 1'b0;
         end
         if (load1) begin
            v1_q <= 1'b1;
            d1_q <= bus.in_data;
            l1_q <= bus.in_last;
         end else if (bus.out1_ready) begin
            v1_q <= 1'b0;
         end
         if (load0 && bus.in_last) cnt0_q <= cnt0_q + CNTW'(1);
         if (load1 && bus.in_last) cnt1_q <= cnt1_q + CNTW'(1);
      end
   end

   assign bus.in_ready   = rdy_c;
   assign bus.out0_valid = v0_q;
   assign bus.out0_data  = d0_q;
   assign bus.out0_last  = l0_q;
   assign bus.out1_valid = v1_q;
   assign bus.out1_data  = d1_q;
   assign bus.out1_last  = l1_q;
   assign busy           = busy_q;
   assign route          = route_q;
   assign pkt_cnt0       = cnt0_q;
   assign pkt_cnt1       = cnt1_q;
endmodule

// File: tb/tb_stream_demux.sv
// Directed bench for stream_demux: vector table for routing/backpressure, hand sequences
// for reset, mid-packet reset and counter wrap (CNTW=4).
module tb_stream_demux;
   logic       clk;
   logic       rst_n;
   logic       busy, route;
   logic [3:0] pkt_cnt0, pkt_cnt1;
   int         checks = 0;
   int         errors = 0;

   stream_demux_if #(.WIDTH(8)) bus ();

   stream_demux #(.WIDTH(8), .CNTW(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .busy     (busy),
      .route    (route),
      .pkt_cnt0 (pkt_cnt0),
      .pkt_cnt1 (pkt_cnt1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       sel, vld;
      logic [7:0] data;
      logic       last, r0, r1;
      logic       e_rdy, e_v0;
      logic [7:0] e_d0;
      logic       e_l0, e_v1;
      logic [7:0] e_d1;
      logic       e_l1, e_busy, e_route;
      logic [3:0] e_c0, e_c1;
   } vec_t;

   vec_t vecs[16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic s, input logic v, input logic [7:0] d, input logic l,
                        input logic r0, input logic r1);
      bus.sel        = s;
      bus.in_valid   = v;
      bus.in_data    = d;
      bus.in_last    = l;
      bus.out0_ready = r0;
      bus.out1_ready = r1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      //            sel vld data  last r0 r1 rdy v0 d0    l0 v1 d1    l1 busy rt c0 c1
      vecs[0]  = '{1, 1, 8'hA5, 1, 1, 1, 1, 0, 8'h00, 0, 1, 8'hA5, 1, 0, 0, 0, 1};
      vecs[1]  = '{0, 1, 8'h11, 0, 1, 1, 1, 1, 8'h11, 0, 0, 8'h00, 0, 1, 0, 0, 1};
      vecs[2]  = '{1, 1, 8'h22, 0, 1, 1, 1, 1, 8'h22, 0, 0, 8'h00, 0, 1, 0, 0, 1};
      vecs[3]  = '{1, 1, 8'h33, 1, 1, 1, 1, 1, 8'h33, 1, 0, 8'h00, 0, 0, 0, 1, 1};
      vecs[4]  = '{0, 1, 8'h44, 1, 0, 1, 0, 1, 8'h33, 1, 0, 8'h00, 0, 0, 0, 1, 1};
      vecs[5]  = '{0, 1, 8'h44, 1, 1, 1, 1, 1, 8'h44, 1, 0, 8'h00, 0, 0, 0, 2, 1};
      vecs[6]  = '{1, 1, 8'h7E, 1, 1, 0, 1, 0, 8'h00, 0, 1, 8'h7E, 1, 0, 0, 2, 2};
      vecs[7]  = '{0, 1, 8'h51, 0, 1, 0, 1, 1, 8'h51, 0, 1, 8'h7E, 1, 1, 0, 2, 2};
      vecs[8]  = '{1, 1, 8'h52, 0, 1, 0, 1, 1, 8'h52, 0, 1, 8'h7E, 1, 1, 0, 2, 2};
      vecs[9]  = '{0, 1, 8'h53, 1, 1, 0, 1, 1, 8'h53, 1, 1, 8'h7E, 1, 0, 0, 3, 2};
      vecs[10] = '{1, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00, 0, 1, 8'h7E, 1, 0, 0, 3, 2};
      vecs[11] = '{1, 1, 8'h60, 0, 1, 1, 1, 0, 8'h00, 0, 1, 8'h60, 0, 1, 1, 3, 2};
      vecs[12] = '{0, 1, 8'h61, 0, 1, 1, 1, 0, 8'h00, 0, 1, 8'h61, 0, 1, 1, 3, 2};
      vecs[13] = '{0, 0, 8'h00, 0, 1, 1, 1, 0, 8'h00, 0, 0, 8'h00, 0, 1, 1, 3, 2};
      vecs[14] = '{0, 1, 8'h62, 1, 1, 1, 1, 0, 8'h00, 0, 1, 8'h62, 1, 0, 0, 3, 3};
      vecs[15] = '{0, 0, 8'h00, 0, 1, 1, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 3, 3};

      // Reset: in_ready held low even with a beat offered
      rst_n = 1'b0;
      drive(1'b0, 1'b1, 8'hEE, 1'b0, 1'b1, 1'b1);
      #1;
      chk("rst_in_ready", 32'(bus.in_ready), 32'h0);
      step();
      step();
      chk("rst_v0", 32'(bus.out0_valid), 32'h0);
      chk("rst_v1", 32'(bus.out1_valid), 32'h0);
      chk("rst_d0", 32'(bus.out0_data), 32'h0);
      chk("rst_d1", 32'(bus.out1_data), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_route", 32'(route), 32'h0);
      chk("rst_c0", 32'(pkt_cnt0), 32'h0);
      chk("rst_c1", 32'(pkt_cnt1), 32'h0);
      drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
      rst_n = 1'b1;
      step();

      for (int i = 0; i < 16; i++) begin
         drive(vecs[i].sel, vecs[i].vld, vecs[i].data, vecs[i].last, vecs[i].r0, vecs[i].r1);
         #1;
         chk($sformatf("v%0d_in_ready", i), 32'(bus.in_ready), 32'(vecs[i].e_rdy));
         step();
         chk($sformatf("v%0d_v0", i), 32'(bus.out0_valid), 32'(vecs[i].e_v0));
         if (vecs[i].e_v0) begin
            chk($sformatf("v%0d_d0", i), 32'(bus.out0_data), 32'(vecs[i].e_d0));
            chk($sformatf("v%0d_l0", i), 32'(bus.out0_last), 32'(vecs[i].e_l0));
         end
         chk($sformatf("v%0d_v1", i), 32'(bus.out1_valid), 32'(vecs[i].e_v1));
         if (vecs[i].e_v1) begin
            chk($sformatf("v%0d_d1", i), 32'(bus.out1_data), 32'(vecs[i].e_d1));
            chk($sformatf("v%0d_l1", i), 32'(bus.out1_last), 32'(vecs[i].e_l1));
         end
         chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
         chk($sformatf("v%0d_route", i), 32'(route), 32'(vecs[i].e_route));
         chk($sformatf("v%0d_c0", i), 32'(pkt_cnt0), 32'(vecs[i].e_c0));
         chk($sformatf("v%0d_c1", i), 32'(pkt_cnt1), 32'(vecs[i].e_c1));
      end

      // Mid-packet reset after beat 2 of a 4-beat packet to port 1
      drive(1'b1, 1'b1, 8'hA1, 1'b0, 1'b1, 1'b1);
      step();
      drive(1'b0, 1'b1, 8'hA2, 1'b0, 1'b1, 1'b0);
      step();
      chk("mid_busy_pre", 32'(busy), 32'h1);
      chk("mid_route_pre", 32'(route), 32'h1);
      chk("mid_v1_pre", 32'(bus.out1_valid), 32'h1);
      rst_n = 1'b0;
      drive(1'b0, 1'b1, 8'hA3, 1'b0, 1'b0, 1'b0);
      #1;
      chk("mid_in_ready_rst", 32'(bus.in_ready), 32'h0);
      step();
      chk("mid_v0", 32'(bus.out0_valid), 32'h0);
      chk("mid_v1", 32'(bus.out1_valid), 32'h0);
      chk("mid_busy", 32'(busy), 32'h0);
      chk("mid_route", 32'(route), 32'h0);
      chk("mid_c0", 32'(pkt_cnt0), 32'h0);
      chk("mid_c1", 32'(pkt_cnt1), 32'h0);
      rst_n = 1'b1;
      drive(1'b0, 1'b1, 8'h99, 1'b1, 1'b1, 1'b1);
      #1;
      chk("post_in_ready", 32'(bus.in_ready), 32'h1);
      step();
      chk("post_v0", 32'(bus.out0_valid), 32'h1);
      chk("post_d0", 32'(bus.out0_data), 32'h99);
      chk("post_v1", 32'(bus.out1_valid), 32'h0);
      chk("post_busy", 32'(busy), 32'h0);
      chk("post_c0", 32'(pkt_cnt0), 32'h1);

      // Counter wrap: 16 more single-beat packets to port 0 (17 total since reset)
      for (int j = 0; j < 16; j++) begin
         drive(1'b0, 1'b1, 8'(j), 1'b1, 1'b1, 1'b1);
         step();
         if (j == 14) chk("wrap_c0_16", 32'(pkt_cnt0), 32'h0);
      end
      chk("wrap_c0_17", 32'(pkt_cnt0), 32'h1);
      chk("wrap_c1", 32'(pkt_cnt1), 32'h0);
      drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
      step();
      chk("end_v0", 32'(bus.out0_valid), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
